heichips25_pwm_bank: RTL and testbench

HEICHIPS25_PWM_BANK -- requirements
Module: heichips25_pwm_bank

---
 rtl/heichips25_pwm_pkg.sv | 23 ++
 rtl/heichips25_pwm_timebase.sv | 80 ++++++++
 rtl/heichips25_pwm_bank.sv | 127 ++++++++++++
 tb/tb_heichips25_pwm_bank.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/heichips25_pwm_pkg.sv
// rtl/heichips25_pwm_pkg.sv - shared register map, control bit layout and mode encoding
package heichips25_pwm_pkg;

   localparam logic [2:0] ADDR_CTRL = 3'd7;

   localparam int UI_STROBE_BIT = 3;
   localparam int UI_RUN_BIT    = 4;

   localparam int CTRL_MODE_BIT  = 0;
   localparam int CTRL_PRESC_LSB = 4;
   localparam int CTRL_PRESC_MSB = 7;

   typedef enum logic {
      MODE_EDGE   = 1'b0,
      MODE_CENTER = 1'b1
   } pwm_mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/heichips25_pwm_timebase.sv
// rtl/heichips25_pwm_timebase.sv - prescaler, up/up-down counter and period boundary detect
module heichips25_pwm_timebase
   import heichips25_pwm_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             mode,
   input  logic [3:0]       presc,
   input  logic             presc_restart,
   output logic [WIDTH-1:0] cnt,
   output logic             boundary
);

   localparam logic [WIDTH-1:0] MAX = '1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [3:0]       pre_q, pre_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   dir_e             dir_q, dir_d;
   logic             tick;

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
         cnt_q <= '0;
         dir_q <= DIR_UP;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
         dir_q <= dir_d;
      end
   end

   always_comb begin
      pre_d    = pre_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      tick     = 1'b0;
      boundary = 1'b0;

      // A prescaler write swallows the tick of that cycle so the count restarts cleanly.
      if (presc_restart) begin
         pre_d = '0;
      end else if (run) begin
         if (pre_q == presc) begin
            pre_d = '0;
            tick  = 1'b1;
         end else begin
            pre_d = pre_q + 4'd1;
         end
      end

      if (tick) begin
         if (pwm_mode_e'(mode) == MODE_EDGE) begin
            cnt_d    = cnt_q + ONE;
            dir_d    = DIR_UP;
            boundary = (cnt_q == MAX);
         end else if (dir_q == DIR_UP) begin
            if (cnt_q == MAX) begin
               cnt_d = cnt_q - ONE;
               dir_d = DIR_DOWN;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end else begin
            cnt_d = cnt_q - ONE;
            if (cnt_q == ONE) begin
               dir_d    = DIR_UP;
               boundary = 1'b1;
            end
         end
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/heichips25_pwm_bank.sv
// rtl/heichips25_pwm_bank.sv - multi-channel PWM with shadowed duties and period-synchronous update
module heichips25_pwm_bank
   import heichips25_pwm_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic                strobe_q, strobe_d;
   logic                strobe_prev_q, strobe_prev_d;
   logic [2:0]          addr_q, addr_d;
   logic [7:0]          data_q, data_d;
   logic [7:0]          ctrl_q, ctrl_d;
   logic                mode_q, mode_d;
   logic [WIDTH-1:0]    shadow_q [CHANNELS];
   logic [WIDTH-1:0]    shadow_d [CHANNELS];
   logic [WIDTH-1:0]    active_q [CHANNELS];
   logic [WIDTH-1:0]    active_d [CHANNELS];
   logic [CHANNELS-1:0] pwm_q, pwm_d;
   logic                tick_q, tick_d;

   logic             run;
   logic             wr;
   logic             presc_restart;
   logic [WIDTH-1:0] cnt;
   logic             boundary;
   logic             unused_ok;

   assign run       = ui_in[UI_RUN_BIT];
   assign wr        = strobe_q & ~strobe_prev_q;
   assign unused_ok = &{1'b0, ena, ui_in[7:5]};

   heichips25_pwm_timebase #(.WIDTH(WIDTH)) u_timebase (
      .clk          (clk),
      .rst          (rst),
      .run          (run),
      .mode         (mode_q),
      .presc        (ctrl_q[CTRL_PRESC_MSB:CTRL_PRESC_LSB]),
      .presc_restart(presc_restart),
      .cnt          (cnt),
      .boundary     (boundary)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         strobe_q      <= 1'b0;
         strobe_prev_q <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
         ctrl_q        <= '0;
         mode_q        <= 1'b0;
         pwm_q         <= '0;
         tick_q        <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            shadow_q[c] <= '0;
            active_q[c] <= '0;
         end
      end else begin
         strobe_q      <= strobe_d;
         strobe_prev_q <= strobe_prev_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         ctrl_q        <= ctrl_d;
         mode_q        <= mode_d;
         pwm_q         <= pwm_d;
         tick_q        <= tick_d;
         for (int c = 0; c < CHANNELS; c++) begin
            shadow_q[c] <= shadow_d[c];
            active_q[c] <= active_d[c];
         end
      end
   end

   always_comb begin
      strobe_d      = ui_in[UI_STROBE_BIT];
      strobe_prev_d = strobe_q;
      addr_d        = ui_in[2:0];
      data_d        = uio_in;
      ctrl_d        = ctrl_q;
      mode_d        = mode_q;
      shadow_d      = shadow_q;
      active_d      = active_q;
      presc_restart = 1'b0;
      tick_d        = boundary;

      // Address and data travel with the strobe so they line up with the detected edge.
      if (wr) begin
         if (addr_q == ADDR_CTRL) begin
            ctrl_d        = data_q;
            presc_restart = 1'b1;
         end else begin
            for (int c = 0; c < CHANNELS; c++) begin
               if (addr_q == 3'(c)) shadow_d[c] = data_q[WIDTH-1:0];
            end
         end
      end

      // Boundary takes the pre-write shadow/ctrl values; a coincident write lands next period.
      if (boundary) begin
         active_d = shadow_q;
         mode_d   = ctrl_q[CTRL_MODE_BIT];
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign pwm_d[c] = run & (cnt < active_q[c]);
   end

   always_comb begin
      uo_out                 = '0;
      uo_out[CHANNELS-1:0]   = pwm_q;
      uo_out[7]              = tick_q;
   end

   assign uio_out = '0;
   assign uio_oe  = '0;

endmodule

// File: tb/tb_heichips25_pwm_bank.sv
// tb/tb_heichips25_pwm_bank.sv - directed bench for heichips25_pwm_bank
module tb_heichips25_pwm_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   logic run_b;
   int   n_cmp = 0;
   int   n_bad = 0;

   int   len, h0, h1, h2, n;
   logic first0, last0;

   heichips25_pwm_bank #(.CHANNELS(4), .WIDTH(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] a, input logic s, input logic [7:0] d);
      ui_in  = {3'b000, run_b, s, a};
      uio_in = d;
   endtask

   task automatic set_run(input logic r);
      run_b    = r;
      ui_in[4] = r;
   endtask

   task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      drive(a, 1'b1, d);
      @(negedge clk);
      drive(a, 1'b0, d);
      @(negedge clk);
   endtask

   task automatic wait_tick(input string tag);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!uo_out[7] && k < 5000);
      check(tag, int'(uo_out[7]), 1);
   endtask

   // Samples one full period (ends on the next tick); optionally pulses a write at sample wr_at.
   task automatic run_period(input int wr_at, input logic [2:0] a, input logic [7:0] d,
                             output int l, output int c0, output int c1, output int c2,
                             output logic f0, output logic z0);
      l = 0; c0 = 0; c1 = 0; c2 = 0; f0 = 1'b0; z0 = 1'b0;
      do begin
         @(negedge clk);
         if (l == 0) f0 = uo_out[0];
         c0 += int'(uo_out[0]);
         c1 += int'(uo_out[1]);
         c2 += int'(uo_out[2]);
         z0 = uo_out[0];
         if (l == wr_at) drive(a, 1'b1, d);
         else if (l == wr_at + 1) drive(a, 1'b0, d);
         l++;
      end while (!uo_out[7] && l < 5000);
   endtask

   initial begin
      rst   = 1'b1;
      ena   = 1'b1;
      run_b = 1'b0;
      ui_in = 8'h00;
      uio_in = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_uo_out", uo_out, 0);
      check("reset_uio_out", uio_out, 0);
      check("reset_uio_oe", uio_oe, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_uo_out", uo_out, 0);

      write_reg(3'd0, 8'h40);
      write_reg(3'd1, 8'h00);
      write_reg(3'd2, 8'hFF);
      write_reg(3'd7, 8'h00);
      set_run(1'b1);
      wait_tick("first_tick");

      run_period(100, 3'd0, 8'hC0, len, h0, h1, h2, first0, last0);
      check("edge_p1_len", len, 256);
      check("edge_p1_ch0_high", h0, 64);
      check("edge_p1_ch1_high", h1, 0);
      check("edge_p1_ch2_high", h2, 255);
      check("unused_bits_zero", int'(uo_out[6:4]), 0);

      run_period(253, 3'd0, 8'h20, len, h0, h1, h2, first0, last0);
      check("edge_p2_ch0_new_duty", h0, 192);
      run_period(-1, 3'd0, 8'h20, len, h0, h1, h2, first0, last0);
      check("edge_p3_coincident_old", h0, 192);
      run_period(-1, 3'd0, 8'h20, len, h0, h1, h2, first0, last0);
      check("edge_p4_coincident_new", h0, 32);

      write_reg(3'd7, 8'h30);
      @(negedge clk);
      drive(3'd0, 1'b1, 8'h10);
      @(negedge clk);
      drive(3'd0, 1'b1, 8'h50);
      repeat (9) @(negedge clk);
      drive(3'd0, 1'b0, 8'h50);
      repeat (2) @(negedge clk);
      run_period(-1, 3'd0, 8'h00, len, h0, h1, h2, first0, last0);
      check("presc_partial_bounded", len < 5000, 1);
      run_period(-1, 3'd0, 8'h00, len, h0, h1, h2, first0, last0);
      check("presc3_len", len, 1024);
      check("held_strobe_single_write", h0, 64);

      write_reg(3'd7, 8'h01);
      write_reg(3'd0, 8'h80);
      run_period(-1, 3'd0, 8'h00, len, h0, h1, h2, first0, last0);
      run_period(-1, 3'd0, 8'h00, len, h0, h1, h2, first0, last0);
      check("center_len", len, 510);
      check("center_ch0_high", h0, 255);
      check("center_ch0_first_high", int'(first0), 1);
      check("center_ch0_last_high", int'(last0), 1);
      check("center_ch1_high", h1, 0);
      check("center_ch2_high", h2, 509);

      set_run(1'b0);
      repeat (2) @(negedge clk);
      check("run_off_outputs", uo_out, 0);
      repeat (20) @(negedge clk);
      check("run_off_hold", uo_out, 0);

      set_run(1'b1);
      repeat (50) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_reset_uo_out", uo_out, 0);
      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) check("mid_reset_first_cycle", uo_out, 0);
      end while (!uo_out[7] && n < 5000);
      check("mid_reset_restart_len", n, 256);
      run_period(-1, 3'd0, 8'h00, len, h0, h1, h2, first0, last0);
      check("mid_reset_len", len, 256);
      check("mid_reset_ch0_cleared", h0, 0);
      check("mid_reset_ch2_cleared", h2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
